code_conv_pipe: RTL

Parametrised, pipelined Gray/binary code converter with per-beat direction select and valid/ready flow control. It is the next-generation replacement for fixed 4-bit combinational Gray-to-binary conversion. It sits between the clock-domain-crossing pointer logic and counter/encoder consumers. The Gray-to-binary prefix-XOR chain is split across `STAGES` registered stages to meet timing at wide `WIDTH`. It sustains one conversion per cycle under backpressure.

---
 rtl/code_conv_pkg.sv | 21 ++
 rtl/code_conv_if.sv | 23 ++
 rtl/code_conv_stage.sv | 65 ++++++
 rtl/code_conv_pipe.sv | 51 +++++
 4 files changed

// File: rtl/code_conv_pkg.sv
// Shared types and stage-geometry helpers for the pipelined Gray/binary converter.
package code_conv_pkg;

  typedef enum logic {
    MODE_G2B = 1'b0,
    MODE_B2G = 1'b1
  } conv_mode_t;

  function automatic int unsigned chunk_size(int unsigned width, int unsigned stages);
    return (stages == 0) ? width : (width + stages - 1) / stages;
  endfunction

  // Low bit index of the binary range resolved by stage k; 0 once the range runs out.
  function automatic int unsigned stage_lo(int unsigned width, int unsigned stages,
                                           int unsigned k);
    int unsigned top;
    top = (k + 1) * chunk_size(width, stages);
    return (top >= width) ? 0 : width - top;
  endfunction

endpackage

// File: rtl/code_conv_if.sv
// Valid/ready stream bundle carrying both sides of the converter.
interface code_conv_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_mode;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/code_conv_stage.sv
// One elastic pipeline stage: resolves its slice of the Gray->binary prefix XOR,
// or (stage 0 only) performs the whole binary->Gray conversion.
module code_conv_stage
  import code_conv_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned K      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  conv_mode_t       up_mode,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output conv_mode_t       dn_mode
);

  localparam int unsigned C     = chunk_size(WIDTH, STAGES);
  // Slice expressed as distance from the MSB: bits MSB-FIRST down to MSB-LAST.
  localparam int unsigned FIRST = K * C;
  localparam int unsigned LAST  = WIDTH - 1 - stage_lo(WIDTH, STAGES, K);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  conv_mode_t       mode_q;
  logic [WIDTH-1:0] work;

  // Bits above this slice arrive already resolved, so the chain carries in from work[MSB-n+1].
  always_comb begin
    work = up_data;
    if (up_mode == MODE_B2G) begin
      if (K == 0) work = up_data ^ (up_data >> 1);
    end else begin
      for (int unsigned n = 1; n < WIDTH; n++) begin
        if (n + 1 > FIRST && n < LAST + 1)
          work[WIDTH-1-n] = work[WIDTH-n] ^ work[WIDTH-1-n];
      end
    end
  end

  assign up_ready = !valid_q || dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= MODE_G2B;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q <= work;
        mode_q <= up_mode;
      end
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;
  assign dn_mode  = mode_q;

endmodule

// File: rtl/code_conv_pipe.sv
// Pipelined Gray/binary converter with per-beat direction and valid/ready flow control.
module code_conv_pipe
  import code_conv_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  code_conv_if.slave bus
);

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_params
    $error("code_conv_pipe: STAGES must be in 1..WIDTH and WIDTH >= 1");
  end

  logic             valid [STAGES+1];
  logic             ready [STAGES+1];
  logic [WIDTH-1:0] data  [STAGES+1];
  conv_mode_t       mode  [STAGES+1];

  assign valid[0]      = bus.in_valid;
  assign data[0]       = bus.in_data;
  assign mode[0]       = conv_mode_t'(bus.in_mode);
  assign bus.in_ready  = ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    code_conv_stage #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .K     (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .up_valid(valid[k]),
      .up_ready(ready[k]),
      .up_data (data[k]),
      .up_mode (mode[k]),
      .dn_valid(valid[k+1]),
      .dn_ready(ready[k+1]),
      .dn_data (data[k+1]),
      .dn_mode (mode[k+1])
    );
  end

  assign ready[STAGES] = bus.out_ready;
  assign bus.out_valid = valid[STAGES];
  assign bus.out_data  = data[STAGES];
  assign bus.out_mode  = mode[STAGES];

endmodule
